// File: rtl/regfile_access_ctrl_if.sv
// Pipeline-side bundle of regfile_access_ctrl: decode read requester and writeback write requester.
interface regfile_access_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rd_grant;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output rd_req, rd_addr_a, rd_addr_b, wr_valid, wr_addr, wr_data,
    input  rd_grant, rd_valid, rd_data_a, rd_data_b, wr_ready
  );

  modport slave (
    input  rd_req, rd_addr_a, rd_addr_b, wr_valid, wr_addr, wr_data,
    output rd_grant, rd_valid, rd_data_a, rd_data_b, wr_ready
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Arbitrates a single-port register file between decode reads and buffered writeback writes,
// with read bypass from the write buffer. Optional statistics counters under RFCTRL_STATS_EN.
module regfile_access_ctrl #(
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  regfile_access_ctrl_if.slave pipe,
  output logic [ADDR_W-1:0]   rf_read_addr_a,
  output logic [ADDR_W-1:0]   rf_read_addr_b,
  output logic [ADDR_W-1:0]   rf_write_address,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                rf_reg_write,
  input  logic [DATA_W-1:0]   rf_data_a,
  input  logic [DATA_W-1:0]   rf_data_b
`ifdef RFCTRL_STATS_EN
  ,
  output logic [15:0]         stat_rd_stall,
  output logic [15:0]         stat_forced_drain
`endif
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_DRAIN, SLOT_FORCED} slot_e;

  wb_entry_t         wb_mem [WB_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, idx;
  logic [CNT_W-1:0]  count_q;
  slot_e             slot;
  logic              full, grant, drain, push;
  logic              hit_a, hit_b, hit_a_q, hit_b_q, zero_a_q, zero_b_q, rd_valid_q;
  logic [DATA_W-1:0] byp_a, byp_b, byp_a_q, byp_b_q, data_a_q, data_b_q;
  logic [DATA_W-1:0] rd_data_a_c, rd_data_b_c;

  // Slot decision: a full buffer always wins so the writeback stage cannot deadlock
  always_comb begin
    slot = SLOT_IDLE;
    full = (count_q == CNT_W'(WB_DEPTH));
    if (!reset_n)              slot = SLOT_IDLE;
    else if (full)             slot = SLOT_FORCED;
    else if (pipe.rd_req)      slot = SLOT_READ;
    else if (count_q != '0)    slot = SLOT_DRAIN;
  end

  assign grant         = (slot == SLOT_READ);
  assign drain         = (slot == SLOT_FORCED) || (slot == SLOT_DRAIN);
  assign pipe.rd_grant = grant;
  assign pipe.wr_ready = reset_n && !full;
  assign push          = pipe.wr_valid && pipe.wr_ready && (pipe.wr_addr != '0);

  assign rf_reg_write     = drain;
  assign rf_write_address = wb_mem[head_q].addr;
  assign rf_write_data    = wb_mem[head_q].data;
  assign rf_read_addr_a   = grant ? pipe.rd_addr_a : '0;
  assign rf_read_addr_b   = grant ? pipe.rd_addr_b : '0;

  // Bypass search: oldest to youngest so the last match (youngest) wins, incoming write last
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    byp_a = '0;
    byp_b = '0;
    idx   = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (wb_mem[idx].addr == pipe.rd_addr_a) begin
          hit_a = 1'b1;
          byp_a = wb_mem[idx].data;
        end
        if (wb_mem[idx].addr == pipe.rd_addr_b) begin
          hit_b = 1'b1;
          byp_b = wb_mem[idx].data;
        end
      end
    end
    if (push && (pipe.wr_addr == pipe.rd_addr_a)) begin
      hit_a = 1'b1;
      byp_a = pipe.wr_data;
    end
    if (push && (pipe.wr_addr == pipe.rd_addr_b)) begin
      hit_b = 1'b1;
      byp_b = pipe.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (push) wb_mem[tail_q] <= '{addr: pipe.wr_addr, data: pipe.wr_data};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)  tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(drain);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      hit_a_q    <= 1'b0;
      hit_b_q    <= 1'b0;
      zero_a_q   <= 1'b0;
      zero_b_q   <= 1'b0;
      byp_a_q    <= '0;
      byp_b_q    <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
    end else begin
      rd_valid_q <= grant;
      if (grant) begin
        hit_a_q  <= hit_a;
        hit_b_q  <= hit_b;
        byp_a_q  <= byp_a;
        byp_b_q  <= byp_b;
        zero_a_q <= (pipe.rd_addr_a == '0);
        zero_b_q <= (pipe.rd_addr_b == '0);
      end
      if (rd_valid_q) begin
        data_a_q <= rd_data_a_c;
        data_b_q <= rd_data_b_c;
      end
    end
  end

  // Register file data arrives one cycle after the grant, so the final mux is combinational
  assign rd_data_a_c    = zero_a_q ? '0 : (hit_a_q ? byp_a_q : rf_data_a);
  assign rd_data_b_c    = zero_b_q ? '0 : (hit_b_q ? byp_b_q : rf_data_b);
  assign pipe.rd_valid  = rd_valid_q;
  assign pipe.rd_data_a = rd_valid_q ? rd_data_a_c : data_a_q;
  assign pipe.rd_data_b = rd_valid_q ? rd_data_b_c : data_b_q;

`ifdef RFCTRL_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_rd_stall     <= '0;
      stat_forced_drain <= '0;
    end else begin
      if (pipe.rd_req && !grant && (stat_rd_stall != 16'hFFFF))
        stat_rd_stall <= stat_rd_stall + 16'd1;
      if ((slot == SLOT_FORCED) && (stat_forced_drain != 16'hFFFF))
        stat_forced_drain <= stat_forced_drain + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: architectural register model plus pending-write queue.
module tb_regfile_access_ctrl;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREG     = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] rf_read_addr_a, rf_read_addr_b, rf_write_address;
  logic [DATA_W-1:0] rf_write_data, rf_data_a, rf_data_b;
  logic              rf_reg_write;
`ifdef RFCTRL_STATS_EN
  logic [15:0]       stat_rd_stall, stat_forced_drain;
`endif

  regfile_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pipe ();

  regfile_access_ctrl #(.WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pipe             (pipe),
    .rf_read_addr_a   (rf_read_addr_a),
    .rf_read_addr_b   (rf_read_addr_b),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_reg_write     (rf_reg_write),
    .rf_data_a        (rf_data_a),
    .rf_data_b        (rf_data_b)
`ifdef RFCTRL_STATS_EN
    ,
    .stat_rd_stall    (stat_rd_stall),
    .stat_forced_drain(stat_forced_drain)
`endif
  );

  initial forever #5 clock = ~clock;

  // Register file model: one access per edge, registered read data
  logic [DATA_W-1:0] rf_mem  [NREG];
  logic [DATA_W-1:0] rf_seed [NREG];
  logic              load_seed = 1'b0;

  always @(posedge clock) begin
    if (load_seed) begin
      for (int i = 0; i < int'(NREG); i++) rf_mem[i] <= rf_seed[i];
    end else if (rf_reg_write) begin
      rf_mem[rf_write_address] <= rf_write_data;
    end else begin
      rf_data_a <= rf_mem[rf_read_addr_a];
      rf_data_b <= rf_mem[rf_read_addr_b];
    end
  end

  // Reference model state
  logic [DATA_W-1:0] arch      [NREG];
  logic [DATA_W-1:0] committed [NREG];
  wr_t               wq[$];
  logic [DATA_W-1:0] last_a, last_b;
  int                checks = 0;
  int                errors = 0;
  int                stall_cnt = 0;
  int                forced_cnt = 0;

  task automatic cycle(input logic rst_n, input logic rq, input logic [ADDR_W-1:0] a,
                       input logic [ADDR_W-1:0] b, input logic wv, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, output bit granted);
    bit full, e_grant, e_write, e_ready;
    logic [DATA_W-1:0] exp_a, exp_b;
    e_grant = 1'b0;
    exp_a = '0;
    exp_b = '0;
    reset_n = rst_n;
    pipe.rd_req = rq; pipe.rd_addr_a = a; pipe.rd_addr_b = b;
    pipe.wr_valid = wv; pipe.wr_addr = wa; pipe.wr_data = wd;
    #3;
    if (!rst_n) begin
      checks++;
      if (pipe.rd_grant !== 1'b0 || pipe.wr_ready !== 1'b0 || rf_reg_write !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: grant=%b ready=%b rf_we=%b, required 0 0 0",
                 pipe.rd_grant, pipe.wr_ready, rf_reg_write);
      end
    end else begin
      full    = (wq.size() == int'(WB_DEPTH));
      e_ready = !full;
      e_grant = rq && !full;
      e_write = full || (!rq && wq.size() > 0);
      checks++;
      if ({pipe.rd_grant, pipe.wr_ready, rf_reg_write} !== {e_grant, e_ready, e_write}) begin
        errors++;
        $display("FAIL slot: grant/ready/rf_we=%b%b%b, required %b%b%b (pending=%0d)",
                 pipe.rd_grant, pipe.wr_ready, rf_reg_write, e_grant, e_ready, e_write, wq.size());
      end
      if (e_write) begin
        checks++;
        if (rf_write_address !== wq[0].a || rf_write_data !== wq[0].d) begin
          errors++;
          $display("FAIL drain_entry: rf write r%0d=%h, required r%0d=%h",
                   rf_write_address, rf_write_data, wq[0].a, wq[0].d);
        end
        committed[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (e_grant) begin
        checks++;
        if (rf_read_addr_a !== a || rf_read_addr_b !== b) begin
          errors++;
          $display("FAIL rf_read_addr: a=%0d b=%0d, required a=%0d b=%0d",
                   rf_read_addr_a, rf_read_addr_b, a, b);
        end
      end
      if (rq && !e_grant) stall_cnt++;
      if (full) forced_cnt++;
      if (wv && e_ready && wa != '0) begin
        wq.push_back('{a: wa, d: wd});
        arch[wa] = wd;
      end
      if (e_grant) begin
        exp_a = (a == '0) ? '0 : arch[a];
        exp_b = (b == '0) ? '0 : arch[b];
      end
    end
    granted = e_grant;
    @(posedge clock);
    #1;
    if (!rst_n) begin
      wq.delete();
      arch = committed;
      last_a = '0; last_b = '0;
      stall_cnt = 0; forced_cnt = 0;
    end
    checks++;
    if (pipe.rd_valid !== e_grant) begin
      errors++;
      $display("FAIL rd_valid: got %b, required %b", pipe.rd_valid, e_grant);
    end
    if (e_grant) begin
      last_a = exp_a;
      last_b = exp_b;
    end
    checks++;
    if (pipe.rd_data_a !== last_a || pipe.rd_data_b !== last_b) begin
      errors++;
      $display("FAIL rd_data(a=%0d b=%0d valid=%b): got %h %h, required %h %h",
               a, b, e_grant, pipe.rd_data_a, pipe.rd_data_b, last_a, last_b);
    end
`ifdef RFCTRL_STATS_EN
    checks++;
    if (int'(stat_rd_stall) != stall_cnt || int'(stat_forced_drain) != forced_cnt) begin
      errors++;
      $display("FAIL stats: stall=%0d forced=%0d, required %0d %0d",
               stat_rd_stall, stat_forced_drain, stall_cnt, forced_cnt);
    end
`endif
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, g);
  endtask

  task automatic test_reset();
    bit g;
    for (int i = 0; i < int'(NREG); i++) rf_seed[i] = $urandom;
    rf_seed[0] = 32'hDEAD_BEEF;
    committed = rf_seed;
    arch = rf_seed;
    load_seed = 1'b1;
    cycle(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'h1, g);
    load_seed = 1'b0;
    cycle(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'h1, g);
    idle(1);
  endtask

  task automatic test_write_only();
    bit g;
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_00AA, g);
    idle(2);
  endtask

  task automatic test_raw_bypass();
    bit g;
    cycle(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'h1234, g);
    idle(2);
  endtask

  task automatic test_youngest();
    bit g;
    cycle(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 32'h1, g);
    cycle(1'b1, 1'b1, 5'd2, 5'd3, 1'b1, 5'd7, 32'h2, g);
    cycle(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, '0, '0, g);
    idle(3);
  endtask

  task automatic test_full();
    bit g;
    for (int i = 0; i < 14; i++)
      cycle(1'b1, 1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'b1, 5'($urandom_range(1, 31)), $urandom, g);
    idle(5);
  endtask

  task automatic test_reg0();
    bit g;
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, g);
    cycle(1'b1, 1'b1, 5'd0, 5'd9, 1'b0, '0, '0, g);
    idle(2);
  endtask

  task automatic test_mid_reset();
    bit g;
    cycle(1'b1, 1'b1, 5'd10, 5'd11, 1'b1, 5'd10, 32'hA0A0_0001, g);
    cycle(1'b1, 1'b1, 5'd11, 5'd12, 1'b1, 5'd11, 32'hA0A0_0002, g);
    cycle(1'b1, 1'b1, 5'd12, 5'd10, 1'b1, 5'd12, 32'hA0A0_0003, g);
    cycle(1'b1, 1'b1, 5'd10, 5'd12, 1'b0, '0, '0, g);
    cycle(1'b0, 1'b1, 5'd10, 5'd12, 1'b0, '0, '0, g);
    idle(3);
    cycle(1'b1, 1'b1, 5'd10, 5'd11, 1'b0, '0, '0, g);
    idle(1);
  endtask

  task automatic test_random();
    bit g;
    bit hold = 1'b0;
    logic [ADDR_W-1:0] ha = '0, hb = '0;
    logic rst;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        ha = 5'($urandom_range(0, 31));
        hb = 5'($urandom_range(0, 31));
      end
      rst = ($urandom_range(0, 99) != 0);
      if (!hold) hold = ($urandom_range(0, 1) == 1);
      cycle(rst, hold, ha, hb, ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom, g);
      if (g || !rst) hold = 1'b0;
    end
    idle(6);
  endtask

  task automatic test_final_drain();
    int bad = 0;
    idle(WB_DEPTH + 2);
    for (int i = 0; i < int'(NREG); i++) begin
      checks++;
      if (rf_mem[i] !== committed[i]) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL rf_contents r%0d: got %h, required %h", i, rf_mem[i], committed[i]);
      end
    end
  endtask

  initial begin
    last_a = '0;
    last_b = '0;
    test_reset();
    test_write_only();
    test_raw_bypass();
    test_youngest();
    test_full();
    test_reg0();
    test_mid_reset();
    test_random();
    test_final_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
